// File: rtl/softsign_grad_unit_if.sv
// Handshake bundle for the Softsign gradient engine: operand pair in, signed Q16.16 gradient out.
interface softsign_grad_unit_if #(
    parameter int DATA_W = 32
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] x_data;
    logic signed [DATA_W-1:0] grad_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic                     busy;

    modport master (
        output in_valid, x_data, grad_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, x_data, grad_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/softsign_grad_unit.sv
// Softsign backward engine: grad_in = g / (1 + |x|)^2 in signed Q16.16,
// computed as two chained 32-step restoring divisions by d = 1 + |x|.
module softsign_grad_unit #(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    softsign_grad_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, DIV1, DIV2, HOLD} state_t;

    localparam logic [DATA_W-1:0] ONE     = DATA_W'(1) << FRAC_W;
    localparam logic [DATA_W-1:0] MAG_MAX = {1'b0, {(DATA_W-1){1'b1}}};

    function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] v);
        logic [DATA_W-1:0] u;
        u = v;
        if (v[DATA_W-1]) u = ~u + DATA_W'(1);
        return u;
    endfunction

    function automatic logic [DATA_W-1:0] sat_mag(input logic signed [DATA_W-1:0] v);
        logic [DATA_W-1:0] m;
        m = mag(v);
        if (m[DATA_W-1]) m = MAG_MAX;
        return m;
    endfunction

    function automatic logic signed [DATA_W-1:0] apply_sign(input logic s,
                                                           input logic [DATA_W-1:0] q);
        logic [DATA_W-1:0] r;
        r = s ? (~q + DATA_W'(1)) : q;
        return $signed(r);
    endfunction

    state_t                   state;
    logic [4:0]               cnt;
    logic                     sign;
    logic [DATA_W-1:0]        divisor;
    logic [DATA_W-1:0]        rem;
    logic [DATA_W-1:0]        sh;
    logic                     in_ready;
    logic                     out_valid;
    logic                     busy;
    logic signed [DATA_W-1:0] out_data;

    logic [DATA_W-1:0] g_mag;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   diff;
    logic              qbit;
    logic [DATA_W-1:0] rem_next;
    logic [DATA_W-1:0] quo_next;

    assign g_mag = mag(bus.grad_data);

    // One restoring step: remainder stays below d < 2^32, so the shifted value
    // fits in 33 bits and the borrow bit of the difference decides the quotient bit.
    always_comb begin
        shifted  = {rem, sh[DATA_W-1]};
        diff     = shifted - {1'b0, divisor};
        qbit     = ~diff[DATA_W];
        rem_next = qbit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
        quo_next = {sh[DATA_W-2:0], qbit};
    end

    // The upper FRAC_W numerator bits are always below d, so they preload the
    // remainder directly and exactly 32 steps remain for the 32-bit quotient.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sign      <= 1'b0;
            divisor   <= '0;
            rem       <= '0;
            sh        <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready) begin
                        sign     <= bus.grad_data[DATA_W-1];
                        divisor  <= ONE + sat_mag(bus.x_data);
                        rem      <= {{(DATA_W-FRAC_W){1'b0}}, g_mag[DATA_W-1:FRAC_W]};
                        sh       <= {g_mag[FRAC_W-1:0], {FRAC_W{1'b0}}};
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= DIV1;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                DIV1: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        rem   <= {{(DATA_W-FRAC_W){1'b0}}, quo_next[DATA_W-1:FRAC_W]};
                        sh    <= {quo_next[FRAC_W-1:0], {FRAC_W{1'b0}}};
                        state <= DIV2;
                    end else begin
                        rem <= rem_next;
                        sh  <= quo_next;
                    end
                end
                DIV2: begin
                    cnt <= cnt + 5'd1;
                    rem <= rem_next;
                    sh  <= quo_next;
                    if (cnt == 5'd31) begin
                        out_data  <= apply_sign(sign, quo_next);
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.busy      = busy;
endmodule

// File: tb/tb_softsign_grad_unit.sv
// Randomised bench for softsign_grad_unit against an arithmetic model of g / (1+|x|)^2.
module tb_softsign_grad_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    softsign_grad_unit_if #(.DATA_W(32)) bus();

    softsign_grad_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    function automatic longint unsigned ref_d(input logic [31:0] x);
        longint unsigned ax;
        ax = x[31] ? (64'h1_0000_0000 - {32'b0, x}) : {32'b0, x};
        if (ax > 64'h7FFF_FFFF) ax = 64'h7FFF_FFFF;
        return 64'd65536 + ax;
    endfunction

    function automatic longint unsigned ref_t(input logic [31:0] x, input logic [31:0] g);
        longint unsigned ag;
        ag = g[31] ? (64'h1_0000_0000 - {32'b0, g}) : {32'b0, g};
        return (ag * 64'd65536) / ref_d(x);
    endfunction

    function automatic logic [31:0] ref_q(input logic [31:0] x, input logic [31:0] g);
        longint unsigned q;
        logic [63:0] r;
        q = (ref_t(x, g) * 64'd65536) / ref_d(x);
        r = g[31] ? (64'd0 - q) : q;
        return r[31:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting at %0t", name, $time);
    endtask

    // Cycle-level expectations derived from accept/handshake events and the model.
    initial begin : compare
        logic rst_e;
        bit pend, acc_next, hs_next, exp_v, exp_r;
        int ncyc, acc_n;
        logic [31:0] exp_data, pend_data;
        pend = 0; acc_next = 0; hs_next = 0; ncyc = 0; acc_n = 0;
        exp_data = '0; pend_data = '0;
        forever begin
            @(posedge clk);
            rst_e = rst;
            @(negedge clk);
            ncyc++;
            if (rst || rst_e) begin
                chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
                chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
                chk("rst_busy", {31'b0, bus.busy}, 32'd0);
                chk("rst_out_data", bus.out_data, 32'd0);
                pend = 0; acc_next = 0; hs_next = 0;
            end else begin
                if (acc_next) begin
                    pend = 1; acc_n = ncyc; exp_data = pend_data;
                end
                if (hs_next) pend = 0;
                acc_next = 0; hs_next = 0;
                exp_v = pend && ((ncyc - acc_n) >= 64);
                exp_r = !pend;
                chk("out_valid", {31'b0, bus.out_valid}, {31'b0, exp_v});
                chk("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_r});
                chk("busy", {31'b0, bus.busy}, {31'b0, pend});
                if (exp_v) chk("out_data", bus.out_data, exp_data);
                if (exp_r && bus.in_valid) begin
                    acc_next = 1;
                    pend_data = ref_q(bus.x_data, bus.grad_data);
                end
                if (exp_v && bus.out_ready) hs_next = 1;
            end
        end
    end

    task automatic run_op(input logic [31:0] x, input logic [31:0] g, input logic [31:0] lit,
                          input bit use_lit, input int ordly, input bit poke);
        bit ok;
        bus.x_data = x; bus.grad_data = g; bus.in_valid = 1'b1;
        bus.out_ready = (ordly == 0);
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin ok = 1; break; end
        end
        if (!ok) timeout_fail("accept");
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.x_data = $urandom; bus.grad_data = $urandom;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin ok = 1; break; end
        end
        if (!ok) timeout_fail("out_valid");
        else if (use_lit) chk("literal", bus.out_data, lit);
        if (ordly > 0) begin
            for (int i = 0; i < ordly; i++) begin
                @(posedge clk); #1;
                if (poke) begin
                    bus.in_valid = 1'($urandom_range(0, 1));
                    bus.x_data = $urandom; bus.grad_data = $urandom;
                end
            end
            bus.in_valid = 1'b0;
            if (use_lit) chk("hold_data", bus.out_data, lit);
            bus.out_ready = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bus.in_valid = 1'b1; bus.x_data = 32'h0001_0000; bus.grad_data = 32'h0001_0000;
        bus.out_ready = 1'b1;
        chk("model_t_trunc", ref_t(32'h0002_0000, 32'h0001_0000), 32'h0000_5555);
        chk("model_t_ext", ref_t(32'h8000_0000, 32'h8000_0000), 32'd65534);
        repeat (3) @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;

        run_op(32'h0000_0000, 32'h0001_0000, 32'h0001_0000, 1, 0, 0);
        run_op(32'h0001_0000, 32'h0001_0000, 32'h0000_4000, 1, 0, 0);
        run_op(32'hFFFD_0000, 32'hFFFE_0000, 32'hFFFF_E000, 1, 0, 0);
        run_op(32'h0003_0000, 32'hFFFE_0000, 32'hFFFF_E000, 1, 0, 0);
        run_op(32'h0002_0000, 32'h0001_0000, 32'h0000_1C71, 1, 0, 0);
        run_op(32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 0);
        run_op(32'h7FFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1, 0, 0);
        run_op(32'h0001_0000, 32'h0001_0000, 32'h0000_4000, 1, 20, 1);

        // Abort an operation mid-DIV2 with reset.
        bus.x_data = 32'h0001_0000; bus.grad_data = 32'h0004_0000; bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.in_ready) break;
        end
        @(posedge clk); #1 bus.in_valid = 1'b0;
        repeat (39) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run_op(32'h0002_0000, 32'h0001_0000, 32'h0000_1C71, 1, 0, 0);

        for (int n = 0; n < 20; n++) begin
            logic [31:0] rx, rg;
            case ($urandom_range(0, 2))
                0: rx = $urandom;
                1: rx = $urandom_range(0, 32'h0004_0000);
                default: rx = 32'd0 - $urandom_range(0, 32'h0004_0000);
            endcase
            rg = ($urandom_range(0, 1) != 0) ? $urandom : (32'd0 - $urandom_range(0, 32'h0010_0000));
            run_op(rx, rg, 32'd0, 0, $urandom_range(0, 3), 0);
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
